// File: rtl/mptw_req_arbiter.sv
// Round-robin arbiter sharing one MPT walker pipeline between NUM_REQ requesters; owner FIFO routes responses back in order.
// Zero-latency combinational request/response paths; a stalled grant is locked until it handshakes, and a full owner FIFO blocks issue.
module mptw_req_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int REQ_WIDTH    = 64,
  parameter int RSP_WIDTH    = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_all_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*REQ_WIDTH-1:0]       req_data_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic [RSP_WIDTH-1:0]               rsp_data_o,
  input  logic [NUM_REQ-1:0]                 rsp_ready_i,
  output logic                               pipe_valid_o,
  output logic [REQ_WIDTH-1:0]               pipe_data_o,
  input  logic                               pipe_ready_i,
  input  logic                               pipe_rsp_valid_i,
  input  logic [RSP_WIDTH-1:0]               pipe_rsp_data_i,
  output logic                               pipe_rsp_ready_o,
  output logic                               busy_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_o,
  output logic                               orphan_rsp_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic             r_active;
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_lock;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] r_owner [MAX_INFLIGHT];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_orphan;

  logic             w_live;
  logic [IDX_W-1:0] w_rr_grant;
  logic [IDX_W-1:0] w_grant;
  logic             w_issue_ok;
  logic             w_push;
  logic             w_nonempty;
  logic [IDX_W-1:0] w_head;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outputs stay quiet during reset and for the first cycle after it.
  assign w_live = rst_ni & r_active;

  always_comb begin : rr_search
    logic w_found;
    int   w_j;
    w_rr_grant = r_rr_ptr;
    w_found    = 1'b0;
    w_j        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid_i[w_j]) begin
        w_rr_grant = IDX_W'(w_j);
        w_found    = 1'b1;
      end
    end
  end

  assign w_grant      = r_lock ? r_lock_idx : w_rr_grant;
  assign w_issue_ok   = w_live & ~flush_all_i & (r_count < CNT_W'(MAX_INFLIGHT));
  assign pipe_valid_o = w_issue_ok & (|req_valid_i);
  assign pipe_data_o  = w_live ? req_data_i[int'(w_grant)*REQ_WIDTH +: REQ_WIDTH] : '0;
  assign w_push       = pipe_valid_o & pipe_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (w_push) req_ready_o[w_grant] = 1'b1;
  end

  assign w_nonempty = (r_count != '0);
  assign w_head     = r_owner[r_rd_ptr];

  always_comb begin
    rsp_valid_o = '0;
    if (rst_ni && pipe_rsp_valid_i && w_nonempty) rsp_valid_o[w_head] = 1'b1;
  end

  // With nothing outstanding the response is swallowed rather than stalling the pipeline.
  assign pipe_rsp_ready_o = (!rst_ni || !w_nonempty) ? 1'b1 : rsp_ready_i[w_head];
  assign rsp_data_o       = rst_ni ? pipe_rsp_data_i : '0;
  assign w_pop            = rst_ni & pipe_rsp_valid_i & pipe_rsp_ready_o & w_nonempty;

  assign busy_o       = rst_ni & w_nonempty;
  assign inflight_o   = rst_ni ? r_count : '0;
  assign orphan_rsp_o = rst_ni & r_orphan;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_active   <= 1'b0;
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_orphan   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      r_orphan <= pipe_rsp_valid_i & ~w_nonempty;

      if (w_push) r_rr_ptr <= (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

      if (flush_all_i || w_push) begin
        r_lock <= 1'b0;
      end else if (pipe_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end

      // Flush wins over a same-cycle pop; that response was already delivered combinationally.
      if (flush_all_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_owner[r_wr_ptr] <= w_grant;
          r_wr_ptr          <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mptw_req_arbiter.sv
// Directed bench for mptw_req_arbiter: grant order, lock, full FIFO, flush, response backpressure, reset.
module tb_mptw_req_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_all_i = 1'b0;
  logic [1:0]   req_valid_i = 2'b00;
  logic [127:0] req_data_i = '0;
  logic [1:0]   req_ready_o;
  logic [1:0]   rsp_valid_o;
  logic [7:0]   rsp_data_o;
  logic [1:0]   rsp_ready_i = 2'b00;
  logic         pipe_valid_o;
  logic [63:0]  pipe_data_o;
  logic         pipe_ready_i = 1'b0;
  logic         pipe_rsp_valid_i = 1'b0;
  logic [7:0]   pipe_rsp_data_i = 8'h00;
  logic         pipe_rsp_ready_o;
  logic         busy_o;
  logic [2:0]   inflight_o;
  logic         orphan_rsp_o;

  localparam logic [63:0] D0 = 64'hA0A0_0000_0000_0001;
  localparam logic [63:0] D1 = 64'hB1B1_0000_0000_0002;
  localparam logic [63:0] D1B = 64'hC2C2_0000_0000_0003;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mptw_req_arbiter #(.NUM_REQ(2), .REQ_WIDTH(64), .RSP_WIDTH(8), .MAX_INFLIGHT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_all_i(flush_all_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .pipe_valid_o(pipe_valid_o), .pipe_data_o(pipe_data_o), .pipe_ready_i(pipe_ready_i),
    .pipe_rsp_valid_i(pipe_rsp_valid_i), .pipe_rsp_data_i(pipe_rsp_data_i),
    .pipe_rsp_ready_o(pipe_rsp_ready_o), .busy_o(busy_o), .inflight_o(inflight_o),
    .orphan_rsp_o(orphan_rsp_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 2'b11; req_data_i = {D1, D0}; pipe_ready_i = 1'b1;
    pipe_rsp_valid_i = 1'b1; pipe_rsp_data_i = 8'h5A; rsp_ready_i = 2'b11;
    tick(); tick(); #1;
    if (pipe_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_pipe_valid: got %b want 0", pipe_valid_o); end n_tests++;
    if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", req_ready_o); end n_tests++;
    if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid_o); end n_tests++;
    if (pipe_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_pipe_rsp_ready: got %b want 1", pipe_rsp_ready_o); end n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_o); end n_tests++;
    if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL rst_inflight: got %0d want 0", inflight_o); end n_tests++;
    if (orphan_rsp_o !== 1'b0) begin n_fail++; $display("FAIL rst_orphan: got %b want 0", orphan_rsp_o); end n_tests++;
    if (pipe_data_o !== 64'd0) begin n_fail++; $display("FAIL rst_pipe_data: got %h want 0", pipe_data_o); end n_tests++;
    if (rsp_data_o !== 8'd0) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data_o); end n_tests++;
    // First cycle after release must still be quiet.
    rst_ni = 1'b1; pipe_rsp_valid_i = 1'b0; #1;
    if (pipe_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_pipe_valid: got %b want 0", pipe_valid_o); end n_tests++;
    if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 00", req_ready_o); end n_tests++;
    if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL post_rst_inflight: got %0d want 0", inflight_o); end n_tests++;
    req_valid_i = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_rsp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [63:0] exp_dat;
    req_valid_i = 2'b11; pipe_ready_i = 1'b1; rsp_ready_i = 2'b11; pipe_rsp_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_dat = (i % 2 == 1) ? D1 : D0;
      if (pipe_valid_o !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want 1", i, pipe_valid_o); end n_tests++;
      if (req_ready_o !== exp_rdy[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready_o, exp_rdy[i]); end n_tests++;
      if (pipe_data_o !== exp_dat) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, pipe_data_o, exp_dat); end n_tests++;
      if (inflight_o !== 3'(i)) begin n_fail++; $display("FAIL rr_inflight[%0d]: got %0d want %0d", i, inflight_o, i); end n_tests++;
      tick();
    end
    // FIFO full: first response pops, but no issue this cycle.
    pipe_rsp_valid_i = 1'b1; pipe_rsp_data_i = 8'h10; #1;
    if (inflight_o !== 3'd4) begin n_fail++; $display("FAIL rr_peak: got %0d want 4", inflight_o); end n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rr_busy: got %b want 1", busy_o); end n_tests++;
    if (pipe_valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_full_block: got %b want 0", pipe_valid_o); end n_tests++;
    if (rsp_data_o !== 8'h10) begin n_fail++; $display("FAIL rr_rsp_data: got %h want 10", rsp_data_o); end n_tests++;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        req_valid_i = 2'b00; pipe_rsp_data_i = 8'h10 + 8'(i); #1;
        if (inflight_o !== 3'(4 - i)) begin n_fail++; $display("FAIL rr_drain_cnt[%0d]: got %0d want %0d", i, inflight_o, 4 - i); end n_tests++;
      end
      if (rsp_valid_o !== exp_rsp[i]) begin n_fail++; $display("FAIL rr_rsp_owner[%0d]: got %b want %b", i, rsp_valid_o, exp_rsp[i]); end n_tests++;
      tick();
    end
    pipe_rsp_valid_i = 1'b0; #1;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rr_idle_busy: got %b want 0", busy_o); end n_tests++;
  endtask

  task automatic test_lock();
    req_valid_i = 2'b01; req_data_i = {D1, D0}; pipe_ready_i = 1'b1; #1;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL lock_pre: got %b want 01", req_ready_o); end n_tests++;
    tick();
    pipe_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin req_valid_i = 2'b11; req_data_i = {D1B, D0}; end
      #1;
      if (pipe_valid_o !== 1'b1) begin n_fail++; $display("FAIL lock_valid[%0d]: got %b want 1", i, pipe_valid_o); end n_tests++;
      if (pipe_data_o !== D0) begin n_fail++; $display("FAIL lock_data[%0d]: got %h want %h", i, pipe_data_o, D0); end n_tests++;
      if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL lock_ready[%0d]: got %b want 00", i, req_ready_o); end n_tests++;
      tick();
    end
    pipe_ready_i = 1'b1; #1;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL lock_release: got %b want 01", req_ready_o); end n_tests++;
    tick(); #1;
    if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL lock_next: got %b want 10", req_ready_o); end n_tests++;
    if (pipe_data_o !== D1B) begin n_fail++; $display("FAIL lock_next_data: got %h want %h", pipe_data_o, D1B); end n_tests++;
    tick();
    req_valid_i = 2'b00; pipe_rsp_valid_i = 1'b1; rsp_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (rsp_valid_o !== ((i == 2) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL lock_rsp[%0d]: got %b", i, rsp_valid_o); end n_tests++;
      tick();
    end
    pipe_rsp_valid_i = 1'b0;
  endtask

  task automatic test_full_resume();
    req_valid_i = 2'b01; pipe_ready_i = 1'b1; pipe_rsp_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (pipe_valid_o !== (i < 4)) begin n_fail++; $display("FAIL full_valid[%0d]: got %b want %b", i, pipe_valid_o, i < 4); end n_tests++;
      if (req_ready_o !== ((i < 4) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL full_ready[%0d]: got %b", i, req_ready_o); end n_tests++;
      tick();
    end
    pipe_rsp_valid_i = 1'b1; rsp_ready_i = 2'b01; #1;
    if (pipe_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_issue: got %b want 0", pipe_valid_o); end n_tests++;
    if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL full_pop_owner: got %b want 01", rsp_valid_o); end n_tests++;
    tick();
    pipe_rsp_valid_i = 1'b0; #1;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL full_resume: got %b want 01", req_ready_o); end n_tests++;
    if (inflight_o !== 3'd3) begin n_fail++; $display("FAIL full_resume_cnt: got %0d want 3", inflight_o); end n_tests++;
    tick();
    req_valid_i = 2'b00; pipe_rsp_valid_i = 1'b1; #1;
    if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL full_trim: got %b want 01", rsp_valid_o); end n_tests++;
    tick();
    pipe_rsp_valid_i = 1'b0;
  endtask

  task automatic test_flush();
    #1;
    if (inflight_o !== 3'd3) begin n_fail++; $display("FAIL flush_pre_cnt: got %0d want 3", inflight_o); end n_tests++;
    flush_all_i = 1'b1; req_valid_i = 2'b11; pipe_ready_i = 1'b1; pipe_rsp_valid_i = 1'b1; rsp_ready_i = 2'b01; #1;
    if (pipe_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", pipe_valid_o); end n_tests++;
    if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL flush_ready: got %b want 00", req_ready_o); end n_tests++;
    if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL flush_rsp_deliver: got %b want 01", rsp_valid_o); end n_tests++;
    tick();
    flush_all_i = 1'b0; req_valid_i = 2'b00; rsp_ready_i = 2'b00; #1;
    if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", inflight_o); end n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy_o); end n_tests++;
    if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL drop_rsp_valid: got %b want 00", rsp_valid_o); end n_tests++;
    if (pipe_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %b want 1", pipe_rsp_ready_o); end n_tests++;
    if (orphan_rsp_o !== 1'b0) begin n_fail++; $display("FAIL orphan_early: got %b want 0", orphan_rsp_o); end n_tests++;
    tick();
    pipe_rsp_valid_i = 1'b0; #1;
    if (orphan_rsp_o !== 1'b1) begin n_fail++; $display("FAIL orphan_pulse: got %b want 1", orphan_rsp_o); end n_tests++;
    tick(); #1;
    if (orphan_rsp_o !== 1'b0) begin n_fail++; $display("FAIL orphan_clear: got %b want 0", orphan_rsp_o); end n_tests++;
    req_valid_i = 2'b11; #1;
    if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL flush_rr_kept: got %b want 10", req_ready_o); end n_tests++;
    tick();
    req_valid_i = 2'b00;
  endtask

  task automatic test_rsp_backpressure();
    pipe_rsp_valid_i = 1'b1; rsp_ready_i = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (rsp_valid_o !== 2'b10) begin n_fail++; $display("FAIL bp_rsp_valid[%0d]: got %b want 10", i, rsp_valid_o); end n_tests++;
      if (pipe_rsp_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, pipe_rsp_ready_o); end n_tests++;
      if (inflight_o !== 3'd1) begin n_fail++; $display("FAIL bp_hold[%0d]: got %0d want 1", i, inflight_o); end n_tests++;
      tick();
    end
    rsp_ready_i = 2'b11; #1;
    if (pipe_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", pipe_rsp_ready_o); end n_tests++;
    tick();
    pipe_rsp_valid_i = 1'b0; #1;
    if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL bp_popped: got %0d want 0", inflight_o); end n_tests++;
  endtask

  task automatic test_reset_mid();
    req_valid_i = 2'b11; pipe_ready_i = 1'b1; #1;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL mid_pre_grant: got %b want 01", req_ready_o); end n_tests++;
    tick();
    rst_ni = 1'b0; pipe_rsp_valid_i = 1'b1; rsp_ready_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (pipe_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid[%0d]: got %b want 0", i, pipe_valid_o); end n_tests++;
      if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rsp[%0d]: got %b want 00", i, rsp_valid_o); end n_tests++;
      if (pipe_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rsp_rdy[%0d]: got %b want 1", i, pipe_rsp_ready_o); end n_tests++;
      if (busy_o !== 1'b0 || inflight_o !== 3'd0) begin n_fail++; $display("FAIL mid_rst_cnt[%0d]: got busy %b cnt %0d want 0 0", i, busy_o, inflight_o); end n_tests++;
      tick();
    end
    rst_ni = 1'b1; pipe_rsp_valid_i = 1'b0; #1;
    if (pipe_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b want 0", pipe_valid_o); end n_tests++;
    tick(); #1;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant: got %b want 01", req_ready_o); end n_tests++;
    tick();
    req_valid_i = 2'b00; #1;
    if (inflight_o !== 3'd1) begin n_fail++; $display("FAIL mid_fresh_cnt: got %0d want 1", inflight_o); end n_tests++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full_resume();
    test_flush();
    test_rsp_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
